// File: rtl/mips_decode_ctrl.sv
// -----------------------------------------------------------------------------
// mips_decode_ctrl
//
// Single-cycle decode/control block for the MIPS-subset datapath. Combines the
// main opcode decoder, the ALU-control decoder and the PC+4 incrementer. All
// decode is combinational; the only clocked element is a sticky, set-only
// illegal-instruction flag.
//
// Build option:
//   JUMP_EN  - when defined, opcode 000010 decodes as j (jump=1) and the
//              jump_target output port is present. When undefined, opcode
//              000010 is illegal, jump is tied low and jump_target is absent.
//
// Ports:
//   clk             in   1   rising-edge clock (sticky flag only)
//   reset           in   1   asynchronous, active-low reset
//   instruction     in  32   current instruction word
//   pc              in  32   current program counter
//   pc_end          out 32   pc + 4 (modulo 2^32, independent of reset)
//   RegDst          out  1   1 = destination rd [15:11], 0 = rt [20:16]
//   jump            out  1   jump instruction (gated low in reset)
//   Branch          out  1   beq (gated low in reset)
//   MemRead         out  1   data-memory read (gated low in reset)
//   MemtoReg        out  1   write-back from memory
//   MemWrite        out  1   data-memory write (gated low in reset)
//   ALUSrc          out  1   1 = ALU operand B is the immediate
//   RegWrite        out  1   register-file write enable (gated low in reset)
//   ALUOP           out  6   main-decoder ALU class
//   alu_control_out out  6   ALU operation code
//   illegal         out  1   unsupported opcode or funct (combinational)
//   illegal_sticky  out  1   registered, set-only illegal flag
//   jump_target     out 32   {pc_end[31:28], instr[25:0], 2'b00} (JUMP_EN only)
// -----------------------------------------------------------------------------
module mips_decode_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  output logic [31:0] pc_end,
  output logic        RegDst,
  output logic        jump,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [5:0]  ALUOP,
  output logic [5:0]  alu_control_out,
  output logic        illegal,
`ifdef JUMP_EN
  output logic        illegal_sticky,
  output logic [31:0] jump_target
`else
  output logic        illegal_sticky
`endif
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOP classes
  localparam logic [5:0] ALUOP_ADD   = 6'd0;
  localparam logic [5:0] ALUOP_SUB   = 6'd1;
  localparam logic [5:0] ALUOP_FUNCT = 6'd2;
  localparam logic [5:0] ALUOP_AND   = 6'd3;
  localparam logic [5:0] ALUOP_OR    = 6'd4;
  localparam logic [5:0] ALUOP_SLT   = 6'd5;

  // ALU operation codes
  localparam logic [5:0] ALU_AND = 6'd0;
  localparam logic [5:0] ALU_OR  = 6'd1;
  localparam logic [5:0] ALU_ADD = 6'd2;
  localparam logic [5:0] ALU_SUB = 6'd6;
  localparam logic [5:0] ALU_SLT = 6'd7;
  localparam logic [5:0] ALU_NOR = 6'd12;

  // Funct field values accepted for R-type
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  // Maps an ALUOP class (and funct for R-type) to an ALU operation code.
  function automatic logic [5:0] alu_code(input logic [5:0] aluop,
                                          input logic [5:0] funct);
    logic [5:0] code;
    code = ALU_ADD;
    case (aluop)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_AND: code = ALU_AND;
      ALUOP_OR:  code = ALU_OR;
      ALUOP_SLT: code = ALU_SLT;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD, FN_ADDU: code = ALU_ADD;
          FN_SUB, FN_SUBU: code = ALU_SUB;
          FN_AND:          code = ALU_AND;
          FN_OR:           code = ALU_OR;
          FN_SLT:          code = ALU_SLT;
          FN_NOR:          code = ALU_NOR;
          default:         code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  // True when the funct field is one the ALU-control decoder supports.
  function automatic logic funct_ok(input logic [5:0] funct);
    logic ok;
    case (funct)
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_SLT, FN_NOR: ok = 1'b1;
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [5:0] opcode_s;
  logic [5:0] funct_s;

  // Raw (ungated) main-decoder controls
  logic       reg_dst_s;
  logic       alu_src_s;
  logic       mem_to_reg_s;
  logic       reg_write_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       branch_s;
  logic       jump_s;
  logic [5:0] aluop_s;
  logic       bad_opcode_s;
  logic       illegal_s;
  logic       illegal_sticky_r;

  assign opcode_s = instruction[31:26];
  assign funct_s  = instruction[5:0];

  // Main opcode decoder: control word and ALU class per opcode.
  always_comb begin
    reg_dst_s    = 1'b0;
    alu_src_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    branch_s     = 1'b0;
    jump_s       = 1'b0;
    aluop_s      = ALUOP_ADD;
    bad_opcode_s = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        reg_dst_s   = 1'b1;
        reg_write_s = 1'b1;
        aluop_s     = ALUOP_FUNCT;
      end
      OP_LW: begin
        alu_src_s    = 1'b1;
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
        mem_read_s   = 1'b1;
        aluop_s      = ALUOP_ADD;
      end
      OP_SW: begin
        alu_src_s   = 1'b1;
        mem_write_s = 1'b1;
        aluop_s     = ALUOP_ADD;
      end
      OP_BEQ: begin
        branch_s = 1'b1;
        aluop_s  = ALUOP_SUB;
      end
      OP_ADDI: begin
        alu_src_s   = 1'b1;
        reg_write_s = 1'b1;
        aluop_s     = ALUOP_ADD;
      end
      OP_ANDI: begin
        alu_src_s   = 1'b1;
        reg_write_s = 1'b1;
        aluop_s     = ALUOP_AND;
      end
      OP_ORI: begin
        alu_src_s   = 1'b1;
        reg_write_s = 1'b1;
        aluop_s     = ALUOP_OR;
      end
      OP_SLTI: begin
        alu_src_s   = 1'b1;
        reg_write_s = 1'b1;
        aluop_s     = ALUOP_SLT;
      end
`ifdef JUMP_EN
      OP_J: begin
        jump_s  = 1'b1;
        aluop_s = ALUOP_ADD;
      end
`else
      OP_J: begin
        // Jumps are not supported in this build.
        bad_opcode_s = 1'b1;
      end
`endif
      default: begin
        bad_opcode_s = 1'b1;
      end
    endcase
  end

  // Illegal when the opcode is unknown, or an R-type carries an unknown funct.
  always_comb begin
    if (bad_opcode_s) begin
      illegal_s = 1'b1;
    end else if (opcode_s == OP_RTYPE) begin
      illegal_s = ~funct_ok(funct_s);
    end else begin
      illegal_s = 1'b0;
    end
  end

  // Output stage: side-effecting controls are held low while reset is asserted.
  always_comb begin
    RegDst          = reg_dst_s;
    ALUSrc          = alu_src_s;
    MemtoReg        = mem_to_reg_s;
    ALUOP           = aluop_s;
    alu_control_out = alu_code(aluop_s, funct_s);
    illegal         = illegal_s;
    if (!reset) begin
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
      Branch   = 1'b0;
      jump     = 1'b0;
    end else begin
      RegWrite = reg_write_s;
      MemWrite = mem_write_s;
      MemRead  = mem_read_s;
      Branch   = branch_s;
      jump     = jump_s;
    end
  end

  assign pc_end = pc + 32'd4;

`ifdef JUMP_EN
  assign jump_target = {pc_end[31:28], instruction[25:0], 2'b00};
`endif

  // Sticky illegal flag: set-only, cleared solely by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_sticky_r <= 1'b0;
    end else if (illegal_s) begin
      illegal_sticky_r <= 1'b1;
    end else begin
      illegal_sticky_r <= illegal_sticky_r;
    end
  end

  assign illegal_sticky = illegal_sticky_r;

endmodule

// File: tb/tb_mips_decode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_decode_ctrl
//
// Directed self-checking bench for mips_decode_ctrl. Expected values are
// hand-computed constants; the control word is compared as
// {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, jump}.
// -----------------------------------------------------------------------------
module tb_mips_decode_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_end;
  logic        RegDst, jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
  logic [5:0]  ALUOP;
  logic [5:0]  alu_control_out;
  logic        illegal;
  logic        illegal_sticky;
`ifdef JUMP_EN
  logic [31:0] jump_target;
`endif

  int n_cmp;
  int n_bad;

  mips_decode_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .instruction     (instruction),
    .pc              (pc),
    .pc_end          (pc_end),
    .RegDst          (RegDst),
    .jump            (jump),
    .Branch          (Branch),
    .MemRead         (MemRead),
    .MemtoReg        (MemtoReg),
    .MemWrite        (MemWrite),
    .ALUSrc          (ALUSrc),
    .RegWrite        (RegWrite),
    .ALUOP           (ALUOP),
    .alu_control_out (alu_control_out),
    .illegal         (illegal),
`ifdef JUMP_EN
    .illegal_sticky  (illegal_sticky),
    .jump_target     (jump_target)
`else
    .illegal_sticky  (illegal_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ctrl;
  assign ctrl = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, jump};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Apply an instruction at a falling edge and let the decode settle.
  task automatic apply(input logic [31:0] instr);
    @(negedge clk);
    instruction = instr;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    instruction = 32'h012A4020;   // add $t0,$t1,$t2
    pc = 32'h00000000;
    #1;

    // Reset state: sticky clear, side-effecting controls gated, others follow.
    check("rst_sticky",  {31'd0, illegal_sticky}, 32'd0);
    check("rst_ctrl",    {24'd0, ctrl}, {24'd0, 8'b1000_0000});
    check("rst_aluop",   {26'd0, ALUOP}, 32'd2);
    check("rst_alu",     {26'd0, alu_control_out}, 32'd2);
    check("pc0",         pc_end, 32'h00000004);

    // lw held in reset: MemRead/RegWrite gated, ALUSrc/MemtoReg still follow.
    apply(32'h8D090004);
    check("rst_lw_ctrl", {24'd0, ctrl}, {24'd0, 8'b0110_0000});

    // Release reset away from the clock edge.
    @(negedge clk);
    reset = 1'b1;
    instruction = 32'h012A4020;
    #1;
    check("add_ctrl",    {24'd0, ctrl}, {24'd0, 8'b1001_0000});
    check("add_aluop",   {26'd0, ALUOP}, 32'd2);
    check("add_alu",     {26'd0, alu_control_out}, 32'd2);
    check("add_illegal", {31'd0, illegal}, 32'd0);

    apply(32'h8D090004);  // lw
    check("lw_ctrl", {24'd0, ctrl}, {24'd0, 8'b0111_1000});
    check("lw_alu",  {26'd0, alu_control_out}, 32'd2);

    apply(32'hAD090004);  // sw
    check("sw_ctrl", {24'd0, ctrl}, {24'd0, 8'b0100_0100});
    check("sw_alu",  {26'd0, alu_control_out}, 32'd2);

    apply(32'h11090003);  // beq
    check("beq_ctrl",  {24'd0, ctrl}, {24'd0, 8'b0000_0010});
    check("beq_aluop", {26'd0, ALUOP}, 32'd1);
    check("beq_alu",   {26'd0, alu_control_out}, 32'd6);

    // Funct sweep
    apply(32'h012A402A); check("slt_alu",  {26'd0, alu_control_out}, 32'd7);
    apply(32'h012A4027); check("nor_alu",  {26'd0, alu_control_out}, 32'd12);
    apply(32'h012A4024); check("and_alu",  {26'd0, alu_control_out}, 32'd0);
    apply(32'h012A4025); check("or_alu",   {26'd0, alu_control_out}, 32'd1);
    apply(32'h012A4022); check("sub_alu",  {26'd0, alu_control_out}, 32'd6);
    apply(32'h012A4023); check("subu_alu", {26'd0, alu_control_out}, 32'd6);
    apply(32'h012A4021); check("addu_alu", {26'd0, alu_control_out}, 32'd2);
    check("addu_illegal", {31'd0, illegal}, 32'd0);

    // Immediate forms
    apply(32'h2128000F);  // addi
    check("addi_ctrl",  {24'd0, ctrl}, {24'd0, 8'b0101_0000});
    check("addi_aluop", {26'd0, ALUOP}, 32'd0);
    check("addi_alu",   {26'd0, alu_control_out}, 32'd2);
    apply(32'h3128000F);  // andi
    check("andi_aluop", {26'd0, ALUOP}, 32'd3);
    check("andi_alu",   {26'd0, alu_control_out}, 32'd0);
    apply(32'h3528000F);  // ori
    check("ori_aluop",  {26'd0, ALUOP}, 32'd4);
    check("ori_alu",    {26'd0, alu_control_out}, 32'd1);
    apply(32'h2928000F);  // slti
    check("slti_ctrl",  {24'd0, ctrl}, {24'd0, 8'b0101_0000});
    check("slti_aluop", {26'd0, ALUOP}, 32'd5);
    check("slti_alu",   {26'd0, alu_control_out}, 32'd7);

    // PC increment boundaries
    pc = 32'hFFFFFFFC; #1;
    check("pc_wrap", pc_end, 32'h00000000);
    pc = 32'h00400000; #1;
    check("pc_mid", pc_end, 32'h00400004);

    // Legal instructions across several edges leave the sticky flag clear.
    @(posedge clk); #1;
    check("sticky_legal", {31'd0, illegal_sticky}, 32'd0);

    // Jump opcode at pc=0x00400000
    apply(32'h08000010);
`ifdef JUMP_EN
    check("j_ctrl",    {24'd0, ctrl}, {24'd0, 8'b0000_0001});
    check("j_illegal", {31'd0, illegal}, 32'd0);
    check("j_target",  jump_target, 32'h00000040);
`else
    check("j_ctrl",    {24'd0, ctrl}, {24'd0, 8'b0000_0000});
    check("j_illegal", {31'd0, illegal}, 32'd1);
    check("j_aluop",   {26'd0, ALUOP}, 32'd0);
    @(posedge clk); #1;
    check("j_sticky",  {31'd0, illegal_sticky}, 32'd1);
    // Clear the flag before the illegal-opcode sequence.
    @(negedge clk);
    reset = 1'b0;
    instruction = 32'h012A4020;
    #1;
    @(negedge clk);
    reset = 1'b1;
    #1;
`endif

    // Illegal opcode 111111
    apply(32'hFC000000);
    check("bad_ctrl",    {24'd0, ctrl}, {24'd0, 8'b0000_0000});
    check("bad_aluop",   {26'd0, ALUOP}, 32'd0);
    check("bad_alu",     {26'd0, alu_control_out}, 32'd2);
    check("bad_illegal", {31'd0, illegal}, 32'd1);
    check("bad_pre",     {31'd0, illegal_sticky}, 32'd0);
    @(posedge clk); #1;
    check("bad_sticky",  {31'd0, illegal_sticky}, 32'd1);

    // Legal instruction follows: flag stays set.
    apply(32'h012A4020);
    @(posedge clk); #1;
    check("sticky_hold", {31'd0, illegal_sticky}, 32'd1);

    // Unsupported funct (sll)
    apply(32'h012A4000);
    check("fn_illegal", {31'd0, illegal}, 32'd1);
    check("fn_alu",     {26'd0, alu_control_out}, 32'd2);

    // Asynchronous clear mid-cycle
    #2;
    reset = 1'b0;
    #1;
    check("async_clr", {31'd0, illegal_sticky}, 32'd0);

    // Illegal present while in reset: flag stays clear until after release.
    apply(32'hFC000000);
    @(posedge clk); #1;
    check("rst_hold_clr", {31'd0, illegal_sticky}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_pre", {31'd0, illegal_sticky}, 32'd0);
    @(posedge clk); #1;
    check("rel_set", {31'd0, illegal_sticky}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
